board_sram_reader: RTL and testbench

//  Read side of the playfield SRAM that the game controller writes.
//  - Cell (x,y) is stored at SRAM_ADDR {x[4:0], y[5:0], 7'd0}; the colour index is in data[2:0].
//  - During each horizontal blank, fetches the next board row into a back line buffer.
//  - Swaps that buffer to the front for display.
//  - Supplies a per-pixel colour index and an in-board flag to the colour mapper, driven by DrawX/DrawY.

---
 rtl/board_sram_reader.sv | 161 ++++++++++++++++
 tb/tb_board_sram_reader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_sram_reader.sv
// Playfield SRAM reader: per-row fetch in h-blank, double line buffer, pixel lookup.
// Optional grid overlay on empty cells: define BOARD_READER_GRID_EN.
module board_sram_reader #(
  parameter int COLS     = 10,
  parameter int ROWS     = 20,
  parameter int CELL_SH  = 4,
  parameter int ORIGIN_X = 240,
  parameter int ORIGIN_Y = 80
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [17:0] sram_addr,
  output logic        sram_rd,
  input  logic [15:0] sram_dq_in,
  output logic [2:0]  pixel_color,
  output logic        in_board,
  output logic        fetch_overrun
);

  localparam int CW = 10 - CELL_SH;
  localparam logic [9:0] X0 = 10'(ORIGIN_X);
  localparam logic [9:0] X1 = 10'(ORIGIN_X + (COLS << CELL_SH));
  localparam logic [9:0] Y0 = 10'(ORIGIN_Y);
  localparam logic [9:0] Y1 = 10'(ORIGIN_Y + (ROWS << CELL_SH));
  localparam logic [4:0] LAST = 5'(COLS - 1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, SAMP, DONE} state_t;

  state_t      state;
  logic [9:0]  dx_q;
  logic        hb_start;
  logic        hb_end;
  logic [4:0]  col;
  logic [5:0]  row;
  logic        rd_q;
  logic [2:0]  back  [COLS];
  logic [2:0]  front [COLS];

  logic [9:0]    ny;
  logic [9:0]    lyt;
  logic [CW-1:0] ry;
  logic          trig;

  assign hb_start = (DrawX == 10'd640) && (dx_q != 10'd640);
  assign hb_end   = (DrawX == 10'd799) && (dx_q != 10'd799);

  // The row is fetched during the blank just before its first line.
  assign ny   = DrawY + 10'd1;
  assign lyt  = ny - Y0;
  assign ry   = lyt[9:CELL_SH];
  assign trig = (ny >= Y0) && (lyt[CELL_SH-1:0] == '0) &&
                (ry < CW'(ROWS));

  assign sram_rd = rd_q & bus_gnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state         <= IDLE;
      dx_q          <= '0;
      col           <= '0;
      row           <= '0;
      bus_req       <= 1'b0;
      rd_q          <= 1'b0;
      sram_addr     <= '0;
      fetch_overrun <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
    end else begin
      dx_q <= DrawX;
      if (hb_end) begin
        for (int i = 0; i < COLS; i++) front[i] <= back[i];
        if (state inside {REQ, ADDR, SAMP}) fetch_overrun <= 1'b1;
        state   <= IDLE;
        bus_req <= 1'b0;
        rd_q    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (hb_start && trig) begin
            row     <= 6'(ry);
            col     <= '0;
            bus_req <= 1'b1;
            state   <= REQ;
          end
          REQ: if (bus_gnt) begin
            sram_addr <= {col, row, 7'd0};
            rd_q      <= 1'b1;
            state     <= ADDR;
          end
          ADDR: if (bus_gnt) state <= SAMP;
          SAMP: begin
            if (!bus_gnt) begin
              state <= ADDR;
            end else begin
              for (int i = 0; i < COLS; i++)
                if (col == 5'(i)) back[i] <= sram_dq_in[2:0];
              if (col == LAST) begin
                bus_req <= 1'b0;
                rd_q    <= 1'b0;
                state   <= DONE;
              end else begin
                col       <= col + 5'd1;
                sram_addr <= {col + 5'd1, row, 7'd0};
                state     <= ADDR;
              end
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [9:0]    lx;
  logic [9:0]    ly;
  logic [CW-1:0] cx;
  logic          inb;
  logic [2:0]    cell_v;
  logic [2:0]    pix_c;

  assign lx  = DrawX - X0;
  assign ly  = DrawY - Y0;
  assign cx  = lx[9:CELL_SH];
  assign inb = (DrawX >= X0) && (DrawX < X1) &&
               (DrawY >= Y0) && (DrawY < Y1);

  always_comb begin
    cell_v = '0;
    for (int i = 0; i < COLS; i++)
      if (cx == CW'(i)) cell_v = front[i];
  end

  always_comb begin
    pix_c = inb ? cell_v : 3'd0;
`ifdef BOARD_READER_GRID_EN
    if (inb && cell_v == 3'd0 &&
        (lx[CELL_SH-1:0] == '0 || ly[CELL_SH-1:0] == '0))
      pix_c = 3'd7;
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pixel_color <= '0;
      in_board    <= 1'b0;
    end else begin
      pixel_color <= pix_c;
      in_board    <= inb;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sram_dq_in[15:3], ly, lx[CELL_SH-1:0]};

endmodule

// File: tb/tb_board_sram_reader.sv
// Bench for board_sram_reader: SRAM array model, line-buffer model,
// randomized board contents and grant stalls.
module tb_board_sram_reader;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [17:0] sram_addr;
  logic        sram_rd;
  logic [15:0] sram_dq_in;
  logic [2:0]  pixel_color;
  logic        in_board;
  logic        fetch_overrun;

  board_sram_reader dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .sram_addr(sram_addr),
    .sram_rd(sram_rd), .sram_dq_in(sram_dq_in),
    .pixel_color(pixel_color), .in_board(in_board),
    .fetch_overrun(fetch_overrun)
  );

  always #5 Clk = ~Clk;

  logic [2:0]  mem [32][64];
  logic [2:0]  mfront [10];
  logic [17:0] rdq [$];
  logic [17:0] last_a;
  logic        have_last;
  int checks = 0;
  int failures = 0;

  assign sram_dq_in = {13'd0, mem[sram_addr[17:13]][sram_addr[12:7]]};

  // Distinct read addresses in issue order.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (sram_rd && (!have_last || sram_addr != last_a)) begin
      rdq.push_back(sram_addr);
      last_a = sram_addr;
      have_last = 1'b1;
    end
  endtask

  function automatic logic [2:0] exp_pix(int x, int y);
    logic [2:0] v;
    if (x < 240 || x >= 400 || y < 80 || y >= 400) return 3'd0;
    v = mfront[(x - 240) / 16];
`ifdef BOARD_READER_GRID_EN
    if (v == 3'd0 && ((x - 240) % 16 == 0 || (y - 80) % 16 == 0))
      return 3'd7;
`endif
    return v;
  endfunction

  function automatic logic exp_inb(int x, int y);
    return (x >= 240 && x < 400 && y >= 80 && y < 400);
  endfunction

  task automatic show(int x, int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
  endtask

  task automatic start_line(int y);
    DrawY = 10'(y);
    DrawX = 10'd639;
    tick();
    DrawX = 10'd640;
    rdq.delete();
    have_last = 1'b0;
    tick();
  endtask

  task automatic end_line();
    DrawX = 10'd799;
    tick();
  endtask

  task automatic wait_req_low(output int n);
    n = 0;
    while (bus_req && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic load_model(int r);
    for (int c = 0; c < 10; c++) mfront[c] = mem[c][r];
  endtask

  task automatic test_reset();
    DrawX = 10'd288;
    DrawY = 10'd80;
    repeat (3) tick();
    checks++;
    if ({bus_req, sram_rd, pixel_color, in_board, fetch_overrun} !== 7'd0 ||
        sram_addr !== 18'd0) begin
      failures++;
      $display("FAIL reset_state: req=%b rd=%b pix=%0d inb=%b ovr=%b addr=%h",
               bus_req, sram_rd, pixel_color, in_board, fetch_overrun, sram_addr);
    end
    DrawX = 10'd0;
    Reset_n = 1'b1;
    tick();
    start_line(79);
    repeat (4) tick();
    checks++;
    if (bus_req !== 1'b1) begin
      failures++;
      $display("FAIL midfetch_req: got %b want 1", bus_req);
    end
    Reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus_req, sram_rd, pixel_color, fetch_overrun} !== 6'd0) begin
      failures++;
      $display("FAIL midfetch_reset: req=%b rd=%b pix=%0d ovr=%b want all 0",
               bus_req, sram_rd, pixel_color, fetch_overrun);
    end
    DrawX = 10'd0;
    Reset_n = 1'b1;
    for (int c = 0; c < 10; c++) mfront[c] = 3'd0;
    tick();
  endtask

  task automatic test_row0_fetch();
    int n;
    for (int c = 0; c < 10; c++) mem[c][0] = 3'(c % 8);
    start_line(79);
    checks++;
    if (bus_req !== 1'b1) begin
      failures++;
      $display("FAIL row0_req_rise: got %b want 1", bus_req);
    end
    wait_req_low(n);
    checks++;
    if (n != 21) begin
      failures++;
      $display("FAIL row0_req_fall: got %0d cycles want 21", n);
    end
    checks++;
    if (rdq.size() != 10) begin
      failures++;
      $display("FAIL row0_nreads: got %0d want 10", rdq.size());
    end else begin
      for (int c = 0; c < 10; c++) begin
        checks++;
        if (rdq[c] !== {5'(c), 6'd0, 7'd0}) begin
          failures++;
          $display("FAIL row0_addr%0d: got %h want %h", c, rdq[c],
                   {5'(c), 6'd0, 7'd0});
        end
      end
    end
    end_line();
    load_model(0);
    show(288, 80);
    checks++;
    if (pixel_color !== 3'd3) begin
      failures++;
      $display("FAIL row0_col3: got %0d want 3", pixel_color);
    end
    for (int c = 0; c < 10; c++) begin
      show(245 + 16 * c, 85);
      checks++;
      if (pixel_color !== exp_pix(245 + 16 * c, 85)) begin
        failures++;
        $display("FAIL row0_cell%0d: got %0d want %0d", c, pixel_color,
                 exp_pix(245 + 16 * c, 85));
      end
    end
  endtask

  task automatic test_overrun();
    for (int c = 0; c < 10; c++) mem[c][1] = 3'($urandom);
    bus_gnt = 1'b0;
    start_line(95);
    repeat (20) tick();
    checks++;
    if (bus_req !== 1'b1 || sram_rd !== 1'b0) begin
      failures++;
      $display("FAIL ovr_pending: req=%b rd=%b want 1 0", bus_req, sram_rd);
    end
    end_line();
    checks++;
    if (fetch_overrun !== 1'b1 || bus_req !== 1'b0 || sram_rd !== 1'b0) begin
      failures++;
      $display("FAIL ovr_flag: ovr=%b req=%b rd=%b want 1 0 0",
               fetch_overrun, bus_req, sram_rd);
    end
    bus_gnt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      show(245 + 16 * c, 100);
      checks++;
      if (pixel_color !== exp_pix(245 + 16 * c, 100)) begin
        failures++;
        $display("FAIL ovr_old%0d: got %0d want %0d", c, pixel_color,
                 exp_pix(245 + 16 * c, 100));
      end
    end
    checks++;
    if (bus_req !== 1'b0) begin
      failures++;
      $display("FAIL ovr_req_after: got %b want 0", bus_req);
    end
  endtask

  task automatic test_gnt_gap();
    int n;
    for (int c = 0; c < 10; c++) mem[c][2] = 3'($urandom);
    mem[4][2] = 3'd5;
    start_line(111);
    repeat (10) tick();
    bus_gnt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (sram_rd !== 1'b0 || sram_addr !== {5'd4, 6'd2, 7'd0}) begin
        failures++;
        $display("FAIL gap_cycle%0d: rd=%b addr=%h want 0 %h", k, sram_rd,
                 sram_addr, {5'd4, 6'd2, 7'd0});
      end
    end
    bus_gnt = 1'b1;
    #1;
    checks++;
    if (sram_rd !== 1'b1 || sram_addr !== {5'd4, 6'd2, 7'd0}) begin
      failures++;
      $display("FAIL gap_reread: rd=%b addr=%h want 1 %h", sram_rd,
               sram_addr, {5'd4, 6'd2, 7'd0});
    end
    wait_req_low(n);
    checks++;
    if (bus_req !== 1'b0 || rdq.size() != 10) begin
      failures++;
      $display("FAIL gap_finish: req=%b reads=%0d want 0 10", bus_req, rdq.size());
    end
    end_line();
    load_model(2);
    for (int c = 0; c < 10; c++) begin
      show(247 + 16 * c, 118);
      checks++;
      if (pixel_color !== exp_pix(247 + 16 * c, 118)) begin
        failures++;
        $display("FAIL gap_cell%0d: got %0d want %0d", c, pixel_color,
                 exp_pix(247 + 16 * c, 118));
      end
    end
    checks++;
    if (fetch_overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky: got %b want 1", fetch_overrun);
    end
  endtask

  task automatic test_no_trigger();
    start_line(399);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus_req !== 1'b0) begin
        failures++;
        $display("FAIL notrig_req%0d: got %b want 0", k, bus_req);
      end
      tick();
    end
    end_line();
    show(239, 200);
    checks++;
    if (in_board !== 1'b0 || pixel_color !== 3'd0) begin
      failures++;
      $display("FAIL edge_x239: inb=%b pix=%0d want 0 0", in_board, pixel_color);
    end
    show(400, 200);
    checks++;
    if (in_board !== 1'b0 || pixel_color !== 3'd0) begin
      failures++;
      $display("FAIL edge_x400: inb=%b pix=%0d want 0 0", in_board, pixel_color);
    end
    show(399, 399);
    checks++;
    if (in_board !== 1'b1 || pixel_color !== exp_pix(399, 399)) begin
      failures++;
      $display("FAIL edge_corner: inb=%b pix=%0d want 1 %0d", in_board,
               pixel_color, exp_pix(399, 399));
    end
  endtask

  task automatic test_random_rows();
    int r, n, x, y;
    for (int it = 0; it < 3; it++) begin
      r = $urandom_range(0, 19);
      for (int c = 0; c < 10; c++) mem[c][r] = 3'($urandom);
      start_line(80 + 16 * r - 1);
      n = 0;
      while (bus_req && n < 200) begin
        bus_gnt = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      bus_gnt = 1'b1;
      checks++;
      if (bus_req !== 1'b0 || rdq.size() != 10) begin
        failures++;
        $display("FAIL rand_fetch%0d: req=%b reads=%0d want 0 10", it,
                 bus_req, rdq.size());
      end
      end_line();
      load_model(r);
      for (int k = 0; k < 20; k++) begin
        x = $urandom_range(200, 639);
        y = $urandom_range(60, 479);
        show(x, y);
        checks++;
        if (pixel_color !== exp_pix(x, y) || in_board !== exp_inb(x, y)) begin
          failures++;
          $display("FAIL rand_pix(%0d,%0d): pix=%0d inb=%b want %0d %b", x, y,
                   pixel_color, in_board, exp_pix(x, y), exp_inb(x, y));
        end
      end
    end
  endtask

  task automatic test_grid();
    int n;
    logic [2:0] want;
    for (int c = 0; c < 10; c++) mem[c][3] = 3'($urandom);
    mem[0][3] = 3'd0;
    start_line(127);
    wait_req_low(n);
    end_line();
    load_model(3);
`ifdef BOARD_READER_GRID_EN
    want = 3'd7;
`else
    want = 3'd0;
`endif
    show(240, 100);
    checks++;
    if (pixel_color !== want) begin
      failures++;
      $display("FAIL grid_line: got %0d want %0d", pixel_color, want);
    end
    show(241, 101);
    checks++;
    if (pixel_color !== 3'd0) begin
      failures++;
      $display("FAIL grid_inner: got %0d want 0", pixel_color);
    end
  endtask

  initial begin
    have_last = 1'b0;
    last_a = '0;
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 64; y++) mem[x][y] = 3'($urandom);
    test_reset();
    test_row0_fetch();
    test_overrun();
    test_gnt_gap();
    test_no_trigger();
    test_random_rows();
    test_grid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
